// File: rtl/serial_paralelo_rx.sv
// -----------------------------------------------------------------------------
// serial_paralelo_rx
//   Receive-side serial-to-parallel converter for one PHY lane. It samples one
//   bit per bit-clock edge, MSB first. It hunts for the COM idle symbol and
//   declares byte alignment after LOCK_COUNT consecutive COMs on one byte grid.
//   Once locked, it presents every received byte together with a valid flag.
//
// Ports
//   clk_32f     in   1  bit clock; all state changes on the rising edge
//   reset       in   1  asynchronous, active-low reset
//   data_in     in   1  serial bit stream, MSB of each byte first
//   data_out    out  8  last received data byte (held between updates)
//   valid_out   out  1  data_out holds a data byte rather than COM
//   byte_strobe out  1  one-cycle pulse on every byte boundary while locked
//   active      out  1  lane locked and aligned
// -----------------------------------------------------------------------------
module serial_paralelo_rx #(
  parameter logic [7:0]  COM_SYMBOL = 8'hBC,
  parameter int unsigned LOCK_COUNT = 4
) (
  input  logic       clk_32f,
  input  logic       reset,
  input  logic       data_in,
  output logic [7:0] data_out,
  output logic       valid_out,
  output logic       byte_strobe,
  output logic       active
);

  typedef enum logic [1:0] {
    ST_UNLOCKED = 2'd0,
    ST_ALIGNING = 2'd1,
    ST_LOCKED   = 2'd2
  } state_e;

  localparam logic [3:0] LOCK_CNT_C = 4'(LOCK_COUNT);

  // The shift register only has to remember the previous seven bits. The
  // incoming bit completes the byte (nsr) that is evaluated on this edge.
  logic [6:0] sr_q, sr_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [3:0] com_cnt_q, com_cnt_d;
  state_e     state_q, state_d;
  logic [7:0] data_out_q, data_out_d;
  logic       valid_q, valid_d;
  logic       strobe_q, strobe_d;
  logic       active_q, active_d;

  logic [7:0] nsr_s;
  logic       boundary_s;
  logic       is_com_s;

  assign nsr_s      = {sr_q, data_in};
  assign boundary_s = (bit_cnt_q == 3'd7);
  assign is_com_s   = (nsr_s == COM_SYMBOL);

  // Next-state logic: symbol search, alignment counting and byte output.
  always_comb begin
    sr_d       = nsr_s[6:0];
    bit_cnt_d  = bit_cnt_q;
    com_cnt_d  = com_cnt_q;
    state_d    = state_q;
    data_out_d = data_out_q;
    valid_d    = valid_q;
    strobe_d   = 1'b0;
    active_d   = active_q;

    case (state_q)
      ST_UNLOCKED: begin
        // Any bit position may start a candidate grid.
        if (is_com_s) begin
          bit_cnt_d = 3'd0;
          com_cnt_d = 4'd1;
          state_d   = ST_ALIGNING;
        end else begin
          state_d   = ST_UNLOCKED;
        end
      end

      ST_ALIGNING: begin
        bit_cnt_d = bit_cnt_q + 3'd1;
        if (boundary_s) begin
          if (is_com_s) begin
            com_cnt_d = com_cnt_q + 4'd1;
            if ((com_cnt_q + 4'd1) == LOCK_CNT_C) begin
              state_d  = ST_LOCKED;
              active_d = 1'b1;
            end else begin
              state_d  = ST_ALIGNING;
            end
          end else begin
            // Grid rejected; the search restarts with the next incoming bit.
            com_cnt_d = 4'd0;
            state_d   = ST_UNLOCKED;
          end
        end else begin
          state_d = ST_ALIGNING;
        end
      end

      ST_LOCKED: begin
        bit_cnt_d = bit_cnt_q + 3'd1;
        if (boundary_s) begin
          strobe_d = 1'b1;
          if (is_com_s) begin
            valid_d = 1'b0;
          end else begin
            data_out_d = nsr_s;
            valid_d    = 1'b1;
          end
        end else begin
          strobe_d = 1'b0;
        end
      end

      default: begin
        state_d   = ST_UNLOCKED;
        bit_cnt_d = 3'd0;
        com_cnt_d = 4'd0;
      end
    endcase
  end

  // State and output registers with asynchronous active-low clear.
  always_ff @(posedge clk_32f or negedge reset) begin
    if (!reset) begin
      sr_q       <= 7'd0;
      bit_cnt_q  <= 3'd0;
      com_cnt_q  <= 4'd0;
      state_q    <= ST_UNLOCKED;
      data_out_q <= 8'h00;
      valid_q    <= 1'b0;
      strobe_q   <= 1'b0;
      active_q   <= 1'b0;
    end else begin
      sr_q       <= sr_d;
      bit_cnt_q  <= bit_cnt_d;
      com_cnt_q  <= com_cnt_d;
      state_q    <= state_d;
      data_out_q <= data_out_d;
      valid_q    <= valid_d;
      strobe_q   <= strobe_d;
      active_q   <= active_d;
    end
  end

  assign data_out    = data_out_q;
  assign valid_out   = valid_q;
  assign byte_strobe = strobe_q;
  assign active      = active_q;

endmodule

// File: tb/tb_serial_paralelo_rx.sv
module tb_serial_paralelo_rx;

  localparam int LOCK = 4;
  localparam int COM  = 188;  // 0xBC

  logic       clk_32f;
  logic       reset;
  logic       data_in;
  logic [7:0] data_out;
  logic       valid_out;
  logic       byte_strobe;
  logic       active;

  int n_checks;
  int n_fail;

  serial_paralelo_rx #(.COM_SYMBOL(8'hBC), .LOCK_COUNT(LOCK)) dut (
    .clk_32f    (clk_32f),
    .reset      (reset),
    .data_in    (data_in),
    .data_out   (data_out),
    .valid_out  (valid_out),
    .byte_strobe(byte_strobe),
    .active     (active)
  );

  initial clk_32f = 1'b0;
  always #5 clk_32f = ~clk_32f;

  // ---------------- reference model ----------------
  // Edges are numbered from the release of reset. The window is the integer
  // value of the last eight bits. In alignment, "anchor" is the edge number of
  // the first COM on the candidate grid; boundaries are multiples of 8 edges
  // after it.
  int         m_n;
  int         m_win;
  int         m_mode;     // 0 = searching, 1 = counting COMs, 2 = locked
  int         m_anchor;
  int         m_good;
  logic [7:0] m_dout;
  logic       m_valid;
  logic       m_strobe;
  logic       m_active;

  task automatic model_reset();
    m_n = 0; m_win = 0; m_mode = 0; m_anchor = 0; m_good = 0;
    m_dout = 8'h00; m_valid = 1'b0; m_strobe = 1'b0; m_active = 1'b0;
  endtask

  task automatic model_edge(input logic b);
    m_n      = m_n + 1;
    m_win    = (m_win * 2 + int'(b)) % 256;
    m_strobe = 1'b0;
    if (m_mode == 0) begin
      if (m_win == COM) begin
        m_mode = 1; m_anchor = m_n; m_good = 1;
      end
    end else if (((m_n - m_anchor) % 8) == 0) begin
      if (m_mode == 1) begin
        if (m_win == COM) begin
          m_good = m_good + 1;
          if (m_good == LOCK) begin
            m_mode = 2; m_active = 1'b1;
          end
        end else begin
          m_mode = 0; m_good = 0;
        end
      end else begin
        m_strobe = 1'b1;
        if (m_win == COM) m_valid = 1'b0;
        else begin
          m_valid = 1'b1; m_dout = 8'(m_win);
        end
      end
    end
  endtask

  // Drive one bit at the falling edge, clock it in, and advance the model.
  task automatic step(input logic b);
    @(negedge clk_32f);
    data_in = b;
    @(posedge clk_32f);
    model_edge(b);
    #1;
  endtask

  task automatic hold_reset();
    reset   = 1'b0;
    data_in = 1'b0;
    model_reset();
    repeat (3) @(posedge clk_32f);
    #1;
    reset = 1'b1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b0;
    model_reset();
    for (int i = 0; i < 6; i++) begin
      @(negedge clk_32f);
      data_in = i[0];
      @(posedge clk_32f);
      #1;
      n_checks++;
      if ({data_out, valid_out, byte_strobe, active} !== 11'd0) begin
        n_fail++;
        $display("FAIL reset_hold: got %h/%b/%b/%b want 00/0/0/0", data_out, valid_out, byte_strobe, active);
      end
    end
    @(posedge clk_32f);
    #1;
    reset = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step(1'b0);
      n_checks++;
      if ({data_out, valid_out, byte_strobe, active} !== 11'd0) begin
        n_fail++;
        $display("FAIL reset_release edge %0d: got %h/%b/%b/%b want 00/0/0/0", m_n, data_out, valid_out, byte_strobe, active);
      end
    end
  endtask

  task automatic test_lock_offset();
    logic [2:0] junk;
    logic [7:0] c;
    hold_reset();
    junk = 3'b101;
    c    = 8'hBC;
    for (int k = 2; k >= 0; k--) step(junk[k]);
    for (int j = 0; j < 4; j++) begin
      for (int k = 7; k >= 0; k--) begin
        step(c[k]);
        n_checks++;
        if ({data_out, valid_out, byte_strobe, active} !== {m_dout, m_valid, m_strobe, m_active}) begin
          n_fail++;
          $display("FAIL lock_offset model edge %0d: got %h/%b/%b/%b want %h/%b/%b/%b", m_n,
                   data_out, valid_out, byte_strobe, active, m_dout, m_valid, m_strobe, m_active);
        end
        if (m_n == 34) begin
          n_checks++;
          if (active !== 1'b0) begin
            n_fail++;
            $display("FAIL lock_early edge 34: active=%b want 0", active);
          end
        end
        if (m_n == 35) begin
          n_checks++;
          if ({active, valid_out, byte_strobe} !== 3'b100) begin
            n_fail++;
            $display("FAIL lock_edge35: active/valid/strobe=%b%b%b want 100", active, valid_out, byte_strobe);
          end
        end
      end
    end
  endtask

  task automatic test_data_stream();
    logic [7:0] bytes_in [4];
    logic [7:0] exp_d    [4];
    logic       exp_v    [4];
    logic [7:0] b;
    bytes_in = '{8'hA5, 8'h3C, 8'hBC, 8'hFF};
    exp_d    = '{8'hA5, 8'h3C, 8'h3C, 8'hFF};
    exp_v    = '{1'b1, 1'b1, 1'b0, 1'b1};
    for (int j = 0; j < 4; j++) begin
      b = bytes_in[j];
      for (int k = 7; k >= 0; k--) begin
        step(b[k]);
        n_checks++;
        if (k == 0) begin
          if ({data_out, valid_out, byte_strobe, active} !== {exp_d[j], exp_v[j], 1'b1, 1'b1}) begin
            n_fail++;
            $display("FAIL data_byte%0d: got %h/%b strobe=%b active=%b want %h/%b strobe=1 active=1",
                     j, data_out, valid_out, byte_strobe, active, exp_d[j], exp_v[j]);
          end
        end else begin
          if (byte_strobe !== 1'b0) begin
            n_fail++;
            $display("FAIL data_strobe_gap byte%0d bit%0d: strobe=%b want 0", j, k, byte_strobe);
          end
        end
      end
    end
  endtask

  task automatic test_align_fail();
    logic [7:0] seq [7];
    logic [7:0] b;
    seq = '{8'hBC, 8'hBC, 8'h12, 8'hBC, 8'hBC, 8'hBC, 8'hBC};
    hold_reset();
    for (int j = 0; j < 7; j++) begin
      b = seq[j];
      for (int k = 7; k >= 0; k--) begin
        step(b[k]);
        n_checks++;
        if ({data_out, valid_out, byte_strobe, active} !== {m_dout, m_valid, m_strobe, m_active}) begin
          n_fail++;
          $display("FAIL align_fail model edge %0d: got %h/%b/%b/%b want %h/%b/%b/%b", m_n,
                   data_out, valid_out, byte_strobe, active, m_dout, m_valid, m_strobe, m_active);
        end
        if (m_n == 55 || m_n == 56) begin
          n_checks++;
          if (active !== (m_n == 56)) begin
            n_fail++;
            $display("FAIL align_fail_lock edge %0d: active=%b want %b", m_n, active, (m_n == 56));
          end
        end
      end
    end
  endtask

  task automatic test_false_match();
    logic [7:0] seq [6];
    logic [7:0] b;
    seq = '{8'h0B, 8'hC0, 8'hBC, 8'hBC, 8'hBC, 8'hBC};
    hold_reset();
    for (int j = 0; j < 6; j++) begin
      b = seq[j];
      for (int k = 7; k >= 0; k--) begin
        step(b[k]);
        n_checks++;
        if ({data_out, valid_out, byte_strobe, active} !== {m_dout, m_valid, m_strobe, m_active}) begin
          n_fail++;
          $display("FAIL false_match model edge %0d: got %h/%b/%b/%b want %h/%b/%b/%b", m_n,
                   data_out, valid_out, byte_strobe, active, m_dout, m_valid, m_strobe, m_active);
        end
        if (m_n == 47 || m_n == 48) begin
          n_checks++;
          if (active !== (m_n == 48)) begin
            n_fail++;
            $display("FAIL false_match_lock edge %0d: active=%b want %b", m_n, active, (m_n == 48));
          end
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] c;
    c = 8'hBC;
    // Lane is locked from the previous test; send part of a data byte.
    step(1'b1); step(1'b0); step(1'b1);
    #2;
    reset = 1'b0;
    model_reset();
    #1;
    n_checks++;
    if ({data_out, valid_out, byte_strobe, active} !== 11'd0) begin
      n_fail++;
      $display("FAIL reset_mid_async: got %h/%b/%b/%b want 00/0/0/0", data_out, valid_out, byte_strobe, active);
    end
    @(posedge clk_32f);
    #1;
    reset = 1'b1;
    for (int j = 0; j < 4; j++) begin
      for (int k = 7; k >= 0; k--) step(c[k]);
      n_checks++;
      if (active !== (j == 3)) begin
        n_fail++;
        $display("FAIL relock com%0d: active=%b want %b", j + 1, active, (j == 3));
      end
    end
  endtask

  task automatic test_random();
    logic [7:0] b;
    int nj;
    hold_reset();
    nj = $urandom_range(0, 7);
    for (int i = 0; i < nj; i++) step(1'($urandom_range(0, 1)));
    for (int j = 0; j < 44; j++) begin
      if (j < 4 || $urandom_range(0, 3) == 0) b = 8'hBC;
      else b = 8'($urandom_range(0, 255));
      for (int k = 7; k >= 0; k--) begin
        step(b[k]);
        n_checks++;
        if ({data_out, valid_out, byte_strobe, active} !== {m_dout, m_valid, m_strobe, m_active}) begin
          n_fail++;
          $display("FAIL random edge %0d: got %h/%b/%b/%b want %h/%b/%b/%b", m_n,
                   data_out, valid_out, byte_strobe, active, m_dout, m_valid, m_strobe, m_active);
        end
      end
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    reset    = 1'b0;
    data_in  = 1'b0;
    model_reset();
    test_reset();
    test_lock_offset();
    test_data_stream();
    test_align_fail();
    test_false_match();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/serial_paralelo_rx.md
Name: serial_paralelo_rx

Overview:
Receive-side serial-to-parallel converter for one PHY lane. It is the counterpart of the transmit parallel-to-serial stage, which sends COM (0xBC) while idle and data bytes while valid.
- Runs on the bit clock and samples one bit per cycle, MSB first.
- Searches the bit stream for COM and achieves byte alignment after LOCK_COUNT consecutive COMs.
- Once locked, emits 8-bit bytes with a valid flag for the downstream 8b-to-32b packer.

Parameters:
COM_SYMBOL, 8'hBC, idle/alignment symbol
LOCK_COUNT, 4, consecutive aligned COMs required to lock (legal range 2..15)

Ports:
clk_32f  input  1  bit clock; all logic on rising edge
reset  input  1  asynchronous, active-low reset
data_in  input  1  serial bit stream, MSB of each byte first
data_out  output  8  received byte (held between updates)
valid_out  output  1  data_out holds a data byte (not COM)
byte_strobe  output  1  one-cycle pulse on every byte boundary while locked
active  output  1  lane locked/aligned

Behaviour:
- Reset (reset=0, asynchronous):
  - sr=0, bit_cnt=0, com_cnt=0, state=UNLOCKED.
  - data_out=8'h00, valid_out=0, byte_strobe=0, active=0.
  - Reset asserted mid-operation clears all of the above immediately, regardless of state.
- Shift register:
  - Every edge: sr <= {sr[6:0], data_in}.
  - nsr = {sr[6:0], data_in} is the byte completed at the current edge.
- States: UNLOCKED, ALIGNING, LOCKED.
- UNLOCKED:
  - Evaluates nsr on every edge.
  - If nsr==COM_SYMBOL: bit_cnt<=0, com_cnt<=1, go ALIGNING.
  - Otherwise remain in UNLOCKED.
- ALIGNING:
  - bit_cnt increments each edge, wrapping 7->0.
  - A byte boundary occurs on the edge where bit_cnt==7, i.e. 8 edges after the previous boundary.
  - At a boundary, if nsr==COM_SYMBOL: com_cnt++. If the new com_cnt==LOCK_COUNT, go LOCKED and set active<=1 on that same edge.
  - At a boundary, if nsr!=COM_SYMBOL: com_cnt<=0 and go UNLOCKED. The search resumes on the next edge; the rejected byte is not re-examined.
  - Outputs stay at their reset values throughout ALIGNING.
- LOCKED:
  - bit_cnt keeps counting mod 8.
  - At each boundary, byte_strobe<=1; at all other edges, byte_strobe<=0.
  - Boundary with nsr!=COM_SYMBOL: data_out<=nsr, valid_out<=1.
  - Boundary with nsr==COM_SYMBOL: valid_out<=0, data_out unchanged.
  - The COM that completes lock is not output: valid_out stays 0 and there is no strobe on the lock edge.
  - LOCKED is held until reset. Invalid bytes are passed through as data; there is no loss-of-lock detection in this block.
- Latency: data_out/valid_out update on the same edge that samples the byte's last bit (LSB). They are visible the cycle after that edge and held for 8 cycles.
- Minimum time to lock from reset, with COM at bit offset 0: LOCK_COUNT*8 edges.
- com_cnt is 4 bits wide; it cannot overflow because lock occurs at LOCK_COUNT.

Test Plan:
- Reset check: hold reset=0 with data_in toggling -> data_out=00, valid_out=0, byte_strobe=0, active=0. Release reset with data_in=0 -> all outputs stay 0.
- Lock with offset: drive 3 junk bits 101, then 4×0xBC MSB-first -> active rises on the edge sampling the LSB of the 4th COM (edge 35 after release); valid_out=0; no strobe on that edge.
- Data stream: after lock, send 0xA5, 0x3C, 0xBC, 0xFF ->
  - byte_strobe pulses every 8 cycles.
  - data_out/valid_out sequence: A5/1, 3C/1, 3C/0, FF/1.
- Aligning failure: send 0xBC, 0xBC, 0x12, then 4×0xBC -> returns to UNLOCKED after 0x12 (active=0). Locks only at the end of the 4th subsequent COM.
- False match: send a pattern where 0xBC appears straddling boundaries, e.g. 0x0B,0xC0 then COMs -> alignment starts at the spurious match. It is rejected at the next boundary, and lock is reached on the true COM grid.
- Reset mid-stream: assert reset while LOCKED mid-byte -> active=0, valid_out=0, data_out=00 immediately without a clock edge. Relock requires 4 fresh COMs.
